// File: rtl/ps2_keyboard_if.sv
// PS/2 host-side keyboard interface: scan-code receiver plus inhibit/RTS command transmitter.
// Optional build macro PS2_RX_PARITY_CHECK_EN drops received frames with bad odd parity.
module ps2_keyboard_if #(
  parameter int INHIBIT_CYCLES  = 5000,
  parameter int START_TIMEOUT   = 750000,
  parameter int XFER_TIMEOUT    = 100000,
  parameter int RX_IDLE_TIMEOUT = 10000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic [7:0] received_data,
  output logic       received_data_en
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_RTS      = 3'd2;
  localparam logic [2:0] ST_WAIT_CLK = 3'd3;
  localparam logic [2:0] ST_SHIFT    = 3'd4;
  localparam logic [2:0] ST_WAIT_ACK = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] START_LAST = 32'(START_TIMEOUT - 1);
  localparam logic [31:0] XFER_LAST  = 32'(XFER_TIMEOUT - 1);
  localparam logic [31:0] IDLE_LAST  = 32'(RX_IDLE_TIMEOUT - 1);

  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_prev_q;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [9:0]  rx_sr_q, rx_sr_d;
  logic [31:0] rx_idle_q, rx_idle_d;
  logic [7:0]  rd_q, rd_d;
  logic        rd_en_q, rd_en_d;
  logic [2:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [9:0]  tx_frame_q, tx_frame_d;
  logic [3:0]  tx_idx_q, tx_idx_d;
  logic        pending_q, pending_d;
  logic        clk_low_q, clk_low_d;
  logic        dat_low_q, dat_low_d;
  logic        sent_q, sent_d;
  logic        err_q, err_d;

  logic        fall_s, dat_s, frame_ok_s;
  logic [10:0] frame_s;

  assign fall_s  = clk_prev_q & ~clk_sync_q[1];
  assign dat_s   = dat_sync_q[1];
  assign frame_s = {dat_s, rx_sr_q};
`ifdef PS2_RX_PARITY_CHECK_EN
  assign frame_ok_s = ~frame_s[0] & frame_s[10] & (^frame_s[9:1]);
`else
  assign frame_ok_s = ~frame_s[0] & frame_s[10];
`endif

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_idle_d  = rx_idle_q;
    rd_d       = rd_q;
    rd_en_d    = 1'b0;
    state_d    = state_q;
    timer_d    = timer_q;
    tx_frame_d = tx_frame_q;
    tx_idx_d   = tx_idx_q;
    pending_d  = pending_q;
    clk_low_d  = clk_low_q;
    dat_low_d  = dat_low_q;
    sent_d     = sent_q;
    err_d      = err_q;

    // Receiver only listens while the transmitter is idle.
    if (state_q != ST_IDLE) begin
      rx_cnt_d  = 4'd0;
      rx_idle_d = 32'd0;
    end else if (fall_s) begin
      rx_idle_d = 32'd0;
      rx_sr_d   = {dat_s, rx_sr_q[9:1]};
      if (rx_cnt_q == 4'd10) begin
        rx_cnt_d = 4'd0;
        if (frame_ok_s) begin
          rd_d    = frame_s[8:1];
          rd_en_d = 1'b1;
        end else begin
          rd_en_d = 1'b0;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + 4'd1;
      end
    end else if (rx_cnt_q != 4'd0) begin
      if (rx_idle_q == IDLE_LAST) begin
        rx_cnt_d  = 4'd0;
        rx_idle_d = 32'd0;
      end else begin
        rx_idle_d = rx_idle_q + 32'd1;
      end
    end else begin
      rx_idle_d = 32'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (send_command || pending_q) begin
          if (rx_cnt_q == 4'd0) begin
            tx_frame_d = {1'b1, ~^the_command, the_command};
            sent_d     = 1'b0;
            err_d      = 1'b0;
            pending_d  = 1'b0;
            clk_low_d  = 1'b1;
            timer_d    = 32'd0;
            rx_cnt_d   = 4'd0;
            rx_idle_d  = 32'd0;
            state_d    = ST_INHIBIT;
          end else begin
            pending_d = 1'b1;
          end
        end else begin
          pending_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          clk_low_d = 1'b0;
          dat_low_d = 1'b1;
          timer_d   = 32'd0;
          state_d   = ST_RTS;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_RTS: begin
        timer_d = 32'd0;
        state_d = ST_WAIT_CLK;
      end
      ST_WAIT_CLK: begin
        if (fall_s) begin
          dat_low_d = ~tx_frame_q[0];
          tx_idx_d  = 4'd1;
          timer_d   = 32'd0;
          state_d   = ST_SHIFT;
        end else if (timer_q == START_LAST) begin
          err_d     = 1'b1;
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_SHIFT: begin
        if (timer_q == XFER_LAST) begin
          err_d     = 1'b1;
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
          if (fall_s) begin
            // Index 9 is the constant 1 stop bit, i.e. DAT released.
            dat_low_d = ~tx_frame_q[tx_idx_q];
            if (tx_idx_q == 4'd9) begin
              state_d = ST_WAIT_ACK;
            end else begin
              tx_idx_d = tx_idx_q + 4'd1;
            end
          end else begin
            tx_idx_d = tx_idx_q;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (timer_q == XFER_LAST) begin
          err_d     = 1'b1;
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
          if (fall_s) begin
            if (!dat_s) begin
              state_d = ST_DONE;
            end else begin
              err_d     = 1'b1;
              clk_low_d = 1'b0;
              dat_low_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end
      ST_DONE: begin
        sent_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Synchronisers, receiver and transmitter state; reset releases both pins at once.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      rx_cnt_q   <= 4'd0;
      rx_sr_q    <= 10'd0;
      rx_idle_q  <= 32'd0;
      rd_q       <= 8'h00;
      rd_en_q    <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= 32'd0;
      tx_frame_q <= 10'd0;
      tx_idx_q   <= 4'd0;
      pending_q  <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
      rx_cnt_q   <= rx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_idle_q  <= rx_idle_d;
      rd_q       <= rd_d;
      rd_en_q    <= rd_en_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_frame_q <= tx_frame_d;
      tx_idx_q   <= tx_idx_d;
      pending_q  <= pending_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
    end
  end

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;
  assign command_was_sent              = sent_q;
  assign error_communication_timed_out = err_q;
  assign received_data                 = rd_q;
  assign received_data_en              = rd_en_q;

endmodule

// File: tb/tb_ps2_keyboard_if.sv
// Directed bench for ps2_keyboard_if with a PS/2 device model on pulled-up open-drain lines.
module tb_ps2_keyboard_if;
  localparam int INH   = 50;
  localparam int START = 2000;
  localparam int XFER  = 3000;
  localparam int RXIDL = 200;
  localparam int HP    = 20;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam int EXP_BADPAR = 0;
`else
  localparam int EXP_BADPAR = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] the_command = 8'h00;
  logic send_command = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire ps2_clk, ps2_dat;
  logic sent, err, rd_en;
  logic [7:0] rd;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int en_high_cnt = 0;
  int en_first_cyc = 0;
  int stop_fall_cyc = 0;
  logic en_prev = 1'b0;
  logic [7:0] last_data = 8'h00;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_keyboard_if #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .XFER_TIMEOUT(XFER),
                    .RX_IDLE_TIMEOUT(RXIDL)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .the_command(the_command), .send_command(send_command),
    .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .command_was_sent(sent),
    .error_communication_timed_out(err), .received_data(rd), .received_data_en(rd_en));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    en_prev <= rd_en;
    if (rd_en) begin
      en_high_cnt <= en_high_cnt + 1;
      last_data <= rd;
      if (!en_prev) begin
        strobe_cnt <= strobe_cnt + 1;
        en_first_cyc <= cyc;
      end
    end
  end

  task automatic device_send_frame(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~f[i];
      repeat (HP/2) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i == 10) stop_fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HP/2) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic pulse_send(input logic [7:0] b);
    the_command = b;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
  endtask

  // Device side of a host-to-device transfer; exp[7:0] data, exp[8] parity.
  task automatic device_host_rx(input logic [8:0] exp, input bit check_len, input string tag);
    int n;
    logic [8:0] got;
    logic stop_bit;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk === 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (check_len) begin
      n_cmp++;
      if (n !== INH) begin n_fail++; $display("FAIL %s inhibit_len: got %0d expected %0d", tag, n, INH); end
    end
    n_cmp++;
    if (ps2_dat !== 1'b0) begin n_fail++; $display("FAIL %s rts_dat: got %b expected 0", tag, ps2_dat); end
    repeat (10) @(negedge clk);
    got = 9'h000;
    stop_bit = 1'b0;
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      if (i < 9) got[i] = ps2_dat;
      if (i == 9) stop_bit = ps2_dat;
      dev_clk_low = 1'b0;
      repeat (HP/2) @(negedge clk);
      if (i == 9) dev_dat_low = 1'b1;
      repeat (HP/2) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL %s tx_bits: got %h expected %h", tag, got, exp); end
    n_cmp++;
    if (stop_bit !== 1'b1) begin n_fail++; $display("FAIL %s tx_stop: got %b expected 1", tag, stop_bit); end
    n_cmp++;
    if (sent !== 1'b1) begin n_fail++; $display("FAIL %s sent: got %b expected 1", tag, sent); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL %s err: got %b expected 0", tag, err); end
    n_cmp++;
    if ({ps2_clk, ps2_dat} !== 2'b11) begin
      n_fail++; $display("FAIL %s lines_released: got %b expected 11", tag, {ps2_clk, ps2_dat});
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rd !== 8'h00 || rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx: got %h/%b expected 00/0", rd, rd_en);
    end
    n_cmp++;
    if (sent !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got %b%b expected 00", sent, err);
    end
    n_cmp++;
    if ({ps2_clk, ps2_dat} !== 2'b11) begin
      n_fail++; $display("FAIL reset_pins: got %b expected 11", {ps2_clk, ps2_dat});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_receive(input logic [7:0] b, input logic par, input string tag);
    int s0, h0;
    s0 = strobe_cnt;
    h0 = en_high_cnt;
    device_send_frame({1'b1, par, b, 1'b0}, 11);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL %s strobes: got %0d expected 1", tag, strobe_cnt - s0); end
    n_cmp++;
    if (last_data !== b) begin n_fail++; $display("FAIL %s data: got %h expected %h", tag, last_data, b); end
    n_cmp++;
    if (en_high_cnt - h0 !== 1) begin n_fail++; $display("FAIL %s en_width: got %0d expected 1", tag, en_high_cnt - h0); end
    n_cmp++;
    if (en_first_cyc - stop_fall_cyc !== 3) begin
      n_fail++; $display("FAIL %s en_latency: got %0d expected 3", tag, en_first_cyc - stop_fall_cyc);
    end
  endtask

  task automatic test_bad_frames();
    int s0;
    s0 = strobe_cnt;
    device_send_frame({1'b1, 1'b1, 8'h1C, 1'b0}, 11);
    n_cmp++;
    if (strobe_cnt - s0 !== EXP_BADPAR) begin
      n_fail++; $display("FAIL bad_parity strobes: got %0d expected %0d", strobe_cnt - s0, EXP_BADPAR);
    end
    if (EXP_BADPAR == 1) begin
      n_cmp++;
      if (last_data !== 8'h1C) begin n_fail++; $display("FAIL bad_parity data: got %h expected 1c", last_data); end
    end
    s0 = strobe_cnt;
    device_send_frame({1'b0, 1'b0, 8'h1C, 1'b0}, 11);
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL bad_stop strobes: got %0d expected 0", strobe_cnt - s0); end
    s0 = strobe_cnt;
    device_send_frame({1'b1, 1'b0, 8'h1C, 1'b1}, 11);
    n_cmp++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL bad_start strobes: got %0d expected 0", strobe_cnt - s0); end
  endtask

  task automatic test_idle_abort();
    int s0;
    s0 = strobe_cnt;
    device_send_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
    repeat (250) @(negedge clk);
    device_send_frame({1'b1, 1'b1, 8'hF0, 1'b0}, 11);
    n_cmp++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL idle_abort strobes: got %0d expected 1", strobe_cnt - s0); end
    n_cmp++;
    if (last_data !== 8'hF0) begin n_fail++; $display("FAIL idle_abort data: got %h expected f0", last_data); end
  endtask

  task automatic test_transmit();
    pulse_send(8'hED);
    device_host_rx(9'h1ED, 1'b1, "tx_ed");
  endtask

  task automatic test_tx_timeout();
    int n;
    pulse_send(8'hED);
    repeat (INH + START - 20) @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err); end
    n = 0;
    while (err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err); end
    n_cmp++;
    if (sent !== 1'b0) begin n_fail++; $display("FAIL timeout_sent: got %b expected 0", sent); end
    @(negedge clk);
    n_cmp++;
    if ({ps2_clk, ps2_dat} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_pins: got %b expected 11", {ps2_clk, ps2_dat});
    end
  endtask

  task automatic test_pending();
    int s0;
    s0 = strobe_cnt;
    fork
      device_send_frame({1'b1, 1'b1, 8'h3A, 1'b0}, 11);
      begin
        repeat (3*HP) @(negedge clk);
        pulse_send(8'hF4);
      end
    join
    n_cmp++;
    if (strobe_cnt - s0 !== 1 || last_data !== 8'h3A) begin
      n_fail++; $display("FAIL pending_rx: got %0d/%h expected 1/3a", strobe_cnt - s0, last_data);
    end
    device_host_rx(9'h0F4, 1'b0, "pending_f4");
  endtask

  initial begin
    test_reset();
    test_receive(8'h1C, 1'b0, "rx_1c");
    test_receive(8'hA5, 1'b1, "rx_a5");
    test_bad_frames();
    test_idle_abort();
    test_transmit();
    test_tx_timeout();
    test_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
